counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
Sequencer for the 8-bit up/down counter (ports clk, rst, enable, direction, counter_out).
- Drives the counter's enable/direction so that counter_out sweeps back and forth between programmable lo/hi bounds.
- Optional dwell at each bound; repeats for a programmed number of full sweeps, then stops.
- Sits beside the counter; counter_out is fed back as an input.

Parameters:
DWELL_W, 8, width of dwell-cycle count
SWEEP_W, 8, width of sweep count / sweep counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a run (sampled in IDLE only)
stop  in  1  abort run, return to IDLE
lo_bound  in  8  lower sweep bound
hi_bound  in  8  upper sweep bound
dwell_cycles  in  DWELL_W  hold cycles at each bound (0 = none)
n_sweeps  in  SWEEP_W  full sweeps to run (0 = run until stop)
counter_out  in  8  feedback from counter
enable  out  1  counter enable (combinational from state and counter_out)
direction  out  1  1 = up, 0 = down (combinational from state)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on normal completion
cfg_err  out  1  one-cycle pulse on rejected start
sweep_cnt  out  SWEEP_W  completed full sweeps in the current run

Behaviour:
Counter contract:
- At each edge with enable=1, the counter steps by ±1 per direction and wraps mod 256. It holds otherwise.

Reset:
- State IDLE; done=0, cfg_err=0, sweep_cnt=0, bound/config registers 0.
- Outputs then: enable=0, direction=1, busy=0.
- rst mid-run aborts immediately. No done pulse is generated.

States: IDLE, SEEK, RUN_UP, DWELL_HI, RUN_DOWN, DWELL_LO.

IDLE:
- enable=0, direction=1.
- start=1 with lo_bound < hi_bound: latch lo/hi/dwell/n_sweeps, clear sweep_cnt, go to SEEK.
- start=1 with lo_bound >= hi_bound: cfg_err pulses on the next cycle; stay in IDLE.

SEEK:
- direction = (counter_out < lo_q).
- enable = (counter_out != lo_q).
- When counter_out == lo_q, go to RUN_UP.

RUN_UP:
- direction=1, enable = (counter_out != hi_q).
- At hi_q: go to DWELL_HI if dwell_q != 0 (load dwell timer = dwell_q), else go to RUN_DOWN.

DWELL_HI:
- enable=0, direction=1.
- Timer decrements each cycle; leaves for RUN_DOWN after exactly dwell_q cycles in this state.

RUN_DOWN:
- direction=0, enable = (counter_out != lo_q).
- At lo_q: sweep_cnt increments (saturates at all-ones).
- If n_sweeps_q != 0 and the new count == n_sweeps_q: done pulses next cycle, go to IDLE.
- Otherwise: go to DWELL_LO (if dwell_q != 0), else to RUN_UP.

DWELL_LO:
- Same as DWELL_HI, then go to RUN_UP.

Timing:
- Each bound hit costs one cycle with enable=0, so counter_out is held for at least one cycle at every bound.

stop:
- stop=1 in any non-IDLE state forces enable=0 combinationally in that cycle.
- Next state is IDLE; no done pulse; sweep_cnt holds its value until the next accepted start.
- stop has priority over start and over bound transitions.

Other rules:
- start while busy is ignored.
- Input bound changes mid-run are ignored (latched copies are used).
- Bounds of lo=0 or hi=255 are legal. The controller never relies on counter wrap.

Optional Feature:
COUNTER_SWEEP_DWELL_EN
- Defined: DWELL_HI/DWELL_LO states and the dwell timer exist, behaving as above.
- Undefined: dwell states and timer are not built; dwell_cycles is ignored. Transitions go directly RUN_UP→RUN_DOWN→RUN_UP.

Test Plan:
1. Counter=0, lo=2, hi=5, dwell=0, n_sweeps=1, pulse start → counter_out per cycle 0,1,2,2,3,4,5,5,4,3,2; then done=1 for one cycle, busy=0, sweep_cnt=1, enable=0.
2. Counter=9, lo=3, hi=6, dwell=0, n_sweeps=1, start → SEEK with direction=0, counter steps 9→3, then the sweep proceeds as in test 1.
3. lo=2, hi=4, dwell=3, n_sweeps=2 (macro defined) → counter holds 4 for 4 cycles (1 transition + 3 dwell) and 2 for 4 cycles between sweeps; done after sweep_cnt=2.
4. n_sweeps=0, lo=10, hi=12; assert stop while counter=11 in RUN_UP → enable=0 in that cycle, counter stays 11, IDLE next cycle, no done pulse, sweep_cnt unchanged.
5. Start with lo=8, hi=8, then with lo=9, hi=3 → cfg_err pulses each time, busy stays 0, enable stays 0.
6. rst asserted mid-RUN_DOWN → next cycle: IDLE, sweep_cnt=0, done=0, enable=0; a start pulse during busy has no effect.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that steers an external 8-bit up/down counter back and forth between latched bounds.
// Optional bound dwell (states DWELL_HI/DWELL_LO plus timer) is built only when COUNTER_SWEEP_DWELL_EN is defined.
module counter_sweep_ctrl #(
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         lo_bound,
  input  logic [7:0]         hi_bound,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [7:0]         counter_out,
  output logic               enable,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    RUN_UP,
    RUN_DOWN
`ifdef COUNTER_SWEEP_DWELL_EN
    ,
    DWELL_HI,
    DWELL_LO
`endif
  } state_t;

  state_t               state;
  logic [7:0]           lo_q;
  logic [7:0]           hi_q;
  logic [SWEEP_W-1:0]   n_q;
  logic [SWEEP_W-1:0]   sweep_next;

`ifdef COUNTER_SWEEP_DWELL_EN
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   timer;
`else
  logic                 unused_dwell;
  assign unused_dwell = ^dwell_cycles;
`endif

  // Completed-sweep count saturates rather than wrapping during endless runs.
  assign sweep_next = (sweep_cnt == '1) ? sweep_cnt : sweep_cnt + SWEEP_W'(1);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef COUNTER_SWEEP_DWELL_EN
      dwell_q   <= '0;
      timer     <= '0;
`endif
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              if (lo_bound < hi_bound) begin
                lo_q      <= lo_bound;
                hi_q      <= hi_bound;
                n_q       <= n_sweeps;
                sweep_cnt <= '0;
`ifdef COUNTER_SWEEP_DWELL_EN
                dwell_q   <= dwell_cycles;
`endif
                state     <= SEEK;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          SEEK: begin
            if (counter_out == lo_q) state <= RUN_UP;
          end
          RUN_UP: begin
            if (counter_out == hi_q) begin
`ifdef COUNTER_SWEEP_DWELL_EN
              timer <= dwell_q;
              state <= (dwell_q != '0) ? DWELL_HI : RUN_DOWN;
`else
              state <= RUN_DOWN;
`endif
            end
          end
          RUN_DOWN: begin
            if (counter_out == lo_q) begin
              sweep_cnt <= sweep_next;
              if (n_q != '0 && sweep_next == n_q) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
`ifdef COUNTER_SWEEP_DWELL_EN
                timer <= dwell_q;
                state <= (dwell_q != '0) ? DWELL_LO : RUN_UP;
`else
                state <= RUN_UP;
`endif
              end
            end
          end
`ifdef COUNTER_SWEEP_DWELL_EN
          // Timer enters at dwell_q, so leaving on 1 gives exactly dwell_q cycles.
          DWELL_HI: begin
            timer <= timer - DWELL_W'(1);
            if (timer == DWELL_W'(1)) state <= RUN_DOWN;
          end
          DWELL_LO: begin
            timer <= timer - DWELL_W'(1);
            if (timer == DWELL_W'(1)) state <= RUN_UP;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Counter steering; a bound hit always drops enable for one cycle.
  always_comb begin
    enable    = 1'b0;
    direction = 1'b1;
    case (state)
      SEEK: begin
        direction = (counter_out < lo_q);
        enable    = (counter_out != lo_q);
      end
      RUN_UP: begin
        enable = (counter_out != hi_q);
      end
      RUN_DOWN: begin
        direction = 1'b0;
        enable    = (counter_out != lo_q);
      end
      default: begin
        enable    = 1'b0;
        direction = 1'b1;
      end
    endcase
    if (stop) enable = 1'b0;
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench for counter_sweep_ctrl: a trajectory model predicts every cycle, a monitor compares.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] lo_bound, hi_bound, dwell_cycles, n_sweeps, counter_out;
  logic       enable, direction, busy, done, cfg_err;
  logic [7:0] sweep_cnt;
  logic       ld;
  logic [7:0] ld_val;

  typedef struct {
    logic [7:0] cnt;
    logic       en;
    logic       dir;
    logic       bsy;
    logic       dn;
    logic       cerr;
    logic [7:0] sweep;
    int         run;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] cnt;
    logic       en;
    logic       dir;
    logic [7:0] sweep;
  } tr_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         passes = 0;
  int         run_id = 0;
  int         cyc_id = 0;
  logic [7:0] m_cnt, m_sweep;

  counter_sweep_ctrl #(.DWELL_W(8), .SWEEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo_bound(lo_bound), .hi_bound(hi_bound), .dwell_cycles(dwell_cycles),
    .n_sweeps(n_sweeps), .counter_out(counter_out), .enable(enable),
    .direction(direction), .busy(busy), .done(done), .cfg_err(cfg_err),
    .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // The counter the controller drives, with a preload for placing it before a run.
  always @(posedge clk) begin
    if (ld) counter_out <= ld_val;
    else if (enable) counter_out <= direction ? counter_out + 8'd1 : counter_out - 8'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want,
                             input int r, input int c);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s run %0d cycle %0d: got %0d expected %0d", name, r, c, got, want);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput("counter_out", counter_out, mon_e.cnt,   mon_e.run, mon_e.cyc);
      checkOutput("enable",      enable,      mon_e.en,    mon_e.run, mon_e.cyc);
      checkOutput("direction",   direction,   mon_e.dir,   mon_e.run, mon_e.cyc);
      checkOutput("busy",        busy,        mon_e.bsy,   mon_e.run, mon_e.cyc);
      checkOutput("done",        done,        mon_e.dn,    mon_e.run, mon_e.cyc);
      checkOutput("cfg_err",     cfg_err,     mon_e.cerr,  mon_e.run, mon_e.cyc);
      checkOutput("sweep_cnt",   sweep_cnt,   mon_e.sweep, mon_e.run, mon_e.cyc);
    end
  end

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input logic [7:0] c, input logic en, input logic dir, input logic bsy,
                      input logic dn, input logic ce, input logic [7:0] sw);
    exp_t e;
    e.cnt = c; e.en = en; e.dir = dir; e.bsy = bsy; e.dn = dn; e.cerr = ce; e.sweep = sw;
    e.run = run_id; e.cyc = cyc_id;
    sb.push_back(e);
    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dn, input logic ce);
    step(m_cnt, 1'b0, 1'b1, 1'b0, dn, ce, m_sweep);
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] k);
    return (k == 8'hFF) ? k : k + 8'd1;
  endfunction

  task automatic applyBadStart(input logic [7:0] lo, input logic [7:0] hi);
    run_id++; cyc_id = 0;
    start = 1'b1; lo_bound = lo; hi_bound = hi; dwell_cycles = 8'd1; n_sweeps = 8'd1;
    idle(1'b0, 1'b0);
    start = 1'b0;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
  endtask

  // One run: predict the counter trajectory, then replay it with noisy inputs and an optional stop/reset.
  task automatic applyStimulus(input logic [7:0] c0, input logic [7:0] lo, input logic [7:0] hi,
                               input logic [7:0] dw, input logic [7:0] n,
                               input int stop_in, input int rst_in);
    tr_t        traj[$];
    tr_t        t;
    logic [7:0] c, k, eff_dw;
    int         stop_at, rst_at, cap;
    logic       finished, aborted;
    run_id++; cyc_id = 0;
`ifdef COUNTER_SWEEP_DWELL_EN
    eff_dw = dw;
`else
    eff_dw = 8'd0;
`endif
    if (m_cnt != c0) begin
      ld = 1'b1; ld_val = c0;
      idle(1'b0, 1'b0);
      ld = 1'b0; m_cnt = c0;
    end
    cap = (n == 8'd0) ? 1500 : 100000;
    c = c0; k = 8'd0; finished = 1'b0;
    while (c != lo) begin
      t = '{cnt: c, en: 1'b1, dir: (c < lo), sweep: 8'd0};
      traj.push_back(t);
      c = (c < lo) ? c + 8'd1 : c - 8'd1;
    end
    t = '{cnt: lo, en: 1'b0, dir: 1'b0, sweep: 8'd0};
    traj.push_back(t);
    while (!finished && traj.size() < cap) begin
      for (int v = int'(lo); v < int'(hi); v++) begin
        t = '{cnt: 8'(v), en: 1'b1, dir: 1'b1, sweep: k}; traj.push_back(t);
      end
      t = '{cnt: hi, en: 1'b0, dir: 1'b1, sweep: k};
      for (int d = 0; d <= int'(eff_dw); d++) traj.push_back(t);
      for (int v = int'(hi); v > int'(lo); v--) begin
        t = '{cnt: 8'(v), en: 1'b1, dir: 1'b0, sweep: k}; traj.push_back(t);
      end
      t = '{cnt: lo, en: 1'b0, dir: 1'b0, sweep: k}; traj.push_back(t);
      k = sat_inc(k);
      if (n != 8'd0 && k == n) finished = 1'b1;
      else begin
        t = '{cnt: lo, en: 1'b0, dir: 1'b1, sweep: k};
        for (int d = 0; d < int'(eff_dw); d++) traj.push_back(t);
      end
    end
    stop_at = (stop_in == -2) ? int'($urandom_range(0, traj.size() - 1)) : stop_in;
    rst_at  = (rst_in == -2)  ? int'($urandom_range(0, traj.size() - 1)) : rst_in;
    if (n == 8'd0 && stop_at < 0 && rst_at < 0) stop_at = int'($urandom_range(0, traj.size() - 1));

    start = 1'b1; lo_bound = lo; hi_bound = hi; dwell_cycles = dw; n_sweeps = n;
    idle(1'b0, 1'b0);
    aborted = 1'b0;
    for (int i = 0; i < traj.size(); i++) begin
      start = ($urandom_range(0, 3) == 0);
      lo_bound = 8'($urandom); hi_bound = 8'($urandom);
      dwell_cycles = 8'($urandom); n_sweeps = 8'($urandom);
      stop = (i == stop_at);
      rst  = (i == rst_at);
      step(traj[i].cnt, traj[i].en && !stop, traj[i].dir, 1'b1, 1'b0, 1'b0, traj[i].sweep);
      if (stop || rst) begin
        aborted = 1'b1;
        m_sweep = rst ? 8'd0 : traj[i].sweep;
        m_cnt = traj[i].cnt;
        if (rst && traj[i].en) m_cnt = traj[i].dir ? m_cnt + 8'd1 : m_cnt - 8'd1;
        stop = 1'b0; rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      m_cnt = lo; m_sweep = k;
      idle(1'b1, 1'b0);
    end else begin
      idle(1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
  endtask

  initial begin
    int lo_r, hi_r, n_r, stop_r, rst_r;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ld = 1'b1; ld_val = 8'd0;
    lo_bound = 8'd0; hi_bound = 8'd0; dwell_cycles = 8'd0; n_sweeps = 8'd0;
    m_cnt = 8'd0; m_sweep = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    step(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; ld = 1'b0;
    idle(1'b0, 1'b0);

    applyStimulus(8'd0, 8'd2, 8'd5, 8'd0, 8'd1, -1, -1);
    applyStimulus(8'd9, 8'd3, 8'd6, 8'd0, 8'd1, -1, -1);
    applyStimulus(8'd3, 8'd2, 8'd4, 8'd3, 8'd2, -1, -1);
    applyStimulus(8'd10, 8'd10, 8'd12, 8'd0, 8'd0, 2, -1);
    applyBadStart(8'd8, 8'd8);
    applyBadStart(8'd9, 8'd3);
    applyStimulus(8'd2, 8'd2, 8'd5, 8'd0, 8'd1, -1, 6);
    applyStimulus(8'd200, 8'd0, 8'd255, 8'd0, 8'd1, -1, -1);
    applyStimulus(8'd255, 8'd254, 8'd255, 8'd1, 8'd3, -1, -1);
    applyStimulus(8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 1100, -1);

    for (int r = 0; r < 12; r++) begin
      lo_r = int'($urandom_range(0, 250));
      hi_r = lo_r + int'($urandom_range(1, 12));
      if (hi_r > 255) hi_r = 255;
      n_r = int'($urandom_range(0, 3));
      stop_r = (n_r == 0 || $urandom_range(0, 3) == 0) ? -2 : -1;
      rst_r  = (stop_r == -1 && $urandom_range(0, 4) == 0) ? -2 : -1;
      applyStimulus(8'($urandom), 8'(lo_r), 8'(hi_r), 8'($urandom_range(0, 3)), 8'(n_r),
                    stop_r, rst_r);
    end

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
